// File: rtl/systola_pkg.sv
// Shared definitions for the systolic array slice.
//   ACT_DW       : activation element width, common to feeder and PE.
//   feed_state_t : activation feeder control states.
package systola_pkg;

    localparam int ACT_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feed_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// One row's valid/data shift register of DEPTH stages with a common enable.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : shift enable; 0 holds every stage
//   d_valid   : valid bit loaded into stage 0
//   d_data    : data loaded into stage 0
//   q_valid   : valid bit of the last stage
//   q_data    : data of the last stage
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          d_valid,
    input  logic [DW-1:0] d_data,
    output logic          q_valid,
    output logic [DW-1:0] q_data
);

    logic [DEPTH-1:0]         vld;
    logic [DEPTH-1:0][DW-1:0] dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            dat <= '0;
        end else if (en) begin
            vld[0] <= d_valid;
            dat[0] <= d_data;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
        end
    end

    assign q_valid = vld[DEPTH-1];
    assign q_data  = dat[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Activation feeder for one column edge of the systolic PE array.
// Accepts one ROWS-element vector per cycle and skews it so row r lags
// row 0 by r cycles; flushes the diagonal tail after the last vector.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : upstream vector valid
//   in_ready  : vector can be accepted this cycle
//   in_vec    : element r in bits [r*DW +: DW]
//   in_last   : final vector of a tile (sampled on acceptance)
//   out_en    : array advance enable; 0 freezes the feeder
//   fire      : per-row PE fire qualifier
//   a_out     : per-row PE activation, zero when fire is 0
//   busy      : feeder not idle
//   done      : one-cycle pulse once the tile has fully drained
module act_skew_feeder
    import systola_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int DW   = ACT_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROWS*DW-1:0] in_vec,
    input  logic               in_last,
    input  logic               out_en,
    output logic [ROWS-1:0]    fire,
    output logic [ROWS*DW-1:0] a_out,
    output logic               busy,
    output logic               done
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = (ROWS > 1) ? CW'(ROWS - 2) : '0;
    // A single-row array has no tail to drain, so the last vector goes straight to DONE.
    localparam feed_state_t TAIL_STATE = (ROWS > 1) ? FLUSH : DONE;

    feed_state_t   state, state_d;
    logic [CW-1:0] flush_cnt, flush_d;
    logic          acc;

    assign in_ready = out_en && (state != FLUSH);
    assign acc      = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_d = state;
        flush_d = flush_cnt;
        case (state)
            IDLE, DONE: begin
                if (acc) begin
                    if (in_last) begin
                        state_d = TAIL_STATE;
                        flush_d = FLUSH_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end else if (state == DONE) begin
                    // DONE always lasts one cycle, stalled or not.
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (acc && in_last) begin
                    state_d = TAIL_STATE;
                    flush_d = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (out_en) begin
                    if (flush_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        flush_d = flush_cnt - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_d;
            flush_cnt <= flush_d;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] elem;
        assign elem = acc ? in_vec[r*DW +: DW] : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .DW    (DW)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .en      (out_en),
            .d_valid (acc),
            .d_data  (elem),
            .q_valid (fire[r]),
            .q_data  (a_out[r*DW +: DW])
        );
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
module tb_act_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 8;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [ROWS*DW-1:0] in_vec;
    logic               in_last;
    logic               out_en;
    logic [ROWS-1:0]    fire;
    logic [ROWS*DW-1:0] a_out;
    logic               busy;
    logic               done;

    logic               in_valid1;
    logic               in_ready1;
    logic [DW-1:0]      in_vec1;
    logic               in_last1;
    logic               out_en1;
    logic [0:0]         fire1;
    logic [DW-1:0]      a_out1;
    logic               busy1;
    logic               done1;

    int checks = 0;
    int errors = 0;

    act_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_last(in_last), .out_en(out_en),
        .fire(fire), .a_out(a_out), .busy(busy), .done(done)
    );

    act_skew_feeder #(.ROWS(1), .DW(DW)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_vec(in_vec1), .in_last(in_last1), .out_en(out_en1),
        .fire(fire1), .a_out(a_out1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_last = 1'b0; out_en = 1'b1;
        in_valid1 = 1'b0; in_vec1 = '0; in_last1 = 1'b0; out_en1 = 1'b1;
        #2;
        checks++;
        if (fire !== '0 || a_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset fire=%b a=%h busy=%b done=%b exp all 0", fire, a_out, busy, done);
        end
        tick();
        tick();
        rst = 1'b0;
        // in_last without in_valid must not start a tile
        in_last = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || fire !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_no_valid busy=%b fire=%b ready=%b exp 0 0 1", busy, fire, in_ready);
        end
        in_last = 1'b0;
    endtask

    task automatic test_single_vector();
        logic [ROWS-1:0]    ef [5];
        logic [ROWS*DW-1:0] ea [5];
        logic               er [5];
        logic               ed [5];
        ef = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        ea = '{32'h0000_0001, 32'h0000_0200, 32'h0003_0000, 32'h0400_0000, 32'h0};
        er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        out_en = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; in_vec = 32'h0403_0201;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_idle got %b exp 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
            checks++;
            if (fire !== ef[k] || a_out !== ea[k] || in_ready !== er[k] || done !== ed[k]) begin
                errors++;
                $display("FAIL single k=%0d fire=%b a=%h ready=%b done=%b exp %b %h %b %b",
                         k, fire, a_out, in_ready, done, ef[k], ea[k], er[k], ed[k]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [ROWS-1:0]    ef;
        logic [ROWS*DW-1:0] ea;
        int                 v;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                in_last  = (k == 3);
                for (int r = 0; r < ROWS; r++) in_vec[r*DW +: DW] = 8'(10 * k + r);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready k=%0d got %b exp 1", k, in_ready);
                end
            end else begin
                in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
            end
            tick();
            ef = '0; ea = '0;
            for (int r = 0; r < ROWS; r++) begin
                v = k - r;
                if (v >= 0 && v <= 3) begin
                    ef[r] = 1'b1;
                    ea[r*DW +: DW] = 8'(10 * v + r);
                end
            end
            checks++;
            if (fire !== ef || a_out !== ea || busy !== (k <= 6) || done !== (k == 6)) begin
                errors++;
                $display("FAIL stream k=%0d fire=%b a=%h busy=%b done=%b exp %b %h %b %b",
                         k, fire, a_out, busy, done, ef, ea, k <= 6, k == 6);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_bubble();
        logic [ROWS-1:0]    ef;
        logic [ROWS*DW-1:0] ea;
        int                 j;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k == 0 || k == 2);
            in_last  = (k == 2);
            for (int r = 0; r < ROWS; r++)
                in_vec[r*DW +: DW] = (k == 0) ? 8'(8'hA0 + r) : (k == 2) ? 8'(8'hB0 + r) : 8'h5A;
            tick();
            ef = '0; ea = '0;
            for (int r = 0; r < ROWS; r++) begin
                j = k - r;
                if (j == 0) begin ef[r] = 1'b1; ea[r*DW +: DW] = 8'(8'hA0 + r); end
                if (j == 2) begin ef[r] = 1'b1; ea[r*DW +: DW] = 8'(8'hB0 + r); end
            end
            checks++;
            if (fire !== ef || a_out !== ea || done !== (k == 5)) begin
                errors++;
                $display("FAIL bubble k=%0d fire=%b a=%h done=%b exp %b %h %b",
                         k, fire, a_out, done, ef, ea, k == 5);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_last = 1'b1; in_vec = 32'h0807_0605; out_en = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
        tick();
        checks++;
        if (fire !== 4'b0010 || a_out !== 32'h0000_0600) begin
            errors++;
            $display("FAIL stall_pre fire=%b a=%h exp 0010 00000600", fire, a_out);
        end
        out_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (fire !== 4'b0010 || a_out !== 32'h0000_0600 || in_ready !== 1'b0 ||
                done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold s=%0d fire=%b a=%h ready=%b done=%b busy=%b exp 0010 00000600 0 0 1",
                         s, fire, a_out, in_ready, done, busy);
            end
        end
        out_en = 1'b1;
        tick();
        checks++;
        if (fire !== 4'b0100 || a_out !== 32'h0007_0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume fire=%b a=%h done=%b exp 0100 00070000 0", fire, a_out, done);
        end
        tick();
        checks++;
        if (fire !== 4'b1000 || a_out !== 32'h0800_0000 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done fire=%b a=%h done=%b exp 1000 08000000 1", fire, a_out, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || fire !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_once done=%b fire=%b busy=%b exp 0 0000 0", done, fire, busy);
        end
    endtask

    task automatic test_reset_mid_tile();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_last = 1'b0;
            for (int r = 0; r < ROWS; r++) in_vec[r*DW +: DW] = 8'(8'hC0 + 4 * k + r);
            tick();
        end
        checks++;
        if (fire !== 4'b0011 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midtile_pre fire=%b busy=%b exp 0011 1", fire, busy);
        end
        in_valid = 1'b0; in_vec = '0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fire !== '0 || a_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midtile_rst fire=%b a=%h busy=%b done=%b exp all 0", fire, a_out, busy, done);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        test_single_vector();
    endtask

    task automatic test_rows1();
        in_valid1 = 1'b1; in_last1 = 1'b1; in_vec1 = 8'd7; out_en1 = 1'b1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL rows1_ready got %b exp 1", in_ready1);
        end
        tick();
        in_valid1 = 1'b0; in_last1 = 1'b0; in_vec1 = '0;
        checks++;
        if (fire1 !== 1'b1 || a_out1 !== 8'd7 || done1 !== 1'b1 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL rows1_fire fire=%b a=%h done=%b ready=%b exp 1 07 1 1",
                     fire1, a_out1, done1, in_ready1);
        end
        tick();
        checks++;
        if (fire1 !== 1'b0 || a_out1 !== 8'd0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rows1_after fire=%b a=%h done=%b busy=%b exp 0 00 0 0",
                     fire1, a_out1, done1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_bubble();
        test_stall();
        test_reset_mid_tile();
        test_rows1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
